i2s_tx: RTL

Stereo I2S master transmitter at the output end of the FX chain. It generates the bit clock, word-select and serial data for the DAC, and issues the one-cycle `sample_en` frame strobe that paces every FX module. Once per frame it latches the parallel stereo sample from the last FX stage and shifts it out MSB-first in standard I2S format, with a one-bit delay after the word-select edge.

---
 rtl/i2s_tx_if.sv | 36 +++
 rtl/i2s_tx.sv | 92 +++++++++
 2 files changed

// File: rtl/i2s_tx_if.sv
// rtl/i2s_tx_if.sv - I2S transmitter bus: parallel stereo sample in, I2S pins and frame strobe out
// Optional mute input is present only when I2S_TX_MUTE_EN is defined.
interface i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic [1:0][DATA_W-1:0] audio_in;
  logic                   sample_en;
  logic                   i2s_bclk;
  logic                   i2s_lrclk;
  logic                   i2s_sdata;
`ifdef I2S_TX_MUTE_EN
  logic                   mute;
`endif

`ifdef I2S_TX_MUTE_EN
  modport master (
    input  audio_in, mute,
    output sample_en, i2s_bclk, i2s_lrclk, i2s_sdata
  );

  modport slave (
    output audio_in, mute,
    input  sample_en, i2s_bclk, i2s_lrclk, i2s_sdata
  );
`else
  modport master (
    input  audio_in,
    output sample_en, i2s_bclk, i2s_lrclk, i2s_sdata
  );

  modport slave (
    output audio_in,
    input  sample_en, i2s_bclk, i2s_lrclk, i2s_sdata
  );
`endif
endinterface

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - stereo I2S master transmitter and FX-chain frame strobe (optional macro I2S_TX_MUTE_EN)
module i2s_tx #(
  parameter int DATA_W   = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic     clk,
  input  logic     reset,
  i2s_tx_if.master bus
);

  localparam int SLOTS  = 2 * DATA_W;
  localparam int DIV_W  = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int SLOT_W = $clog2(SLOTS);

  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(BCLK_DIV / 2);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(DATA_W);

  // An odd or too-small divider cannot give a symmetric bit clock.
  generate
    if ((BCLK_DIV < 2) || ((BCLK_DIV % 2) != 0)) begin : g_bad_div
      $error("i2s_tx: BCLK_DIV must be even and >= 2");
    end
  endgenerate

  logic [DIV_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot;
  logic [DIV_W-1:0]  div_nxt;
  logic [SLOT_W-1:0] slot_nxt;
  logic              div_wrap;
  logic              latch;
  logic [SLOTS-1:0]  shreg;
  logic [SLOTS-1:0]  load_word;
  logic              sample_en_q;
  logic              bclk_q;
  logic              lrclk_q;
  logic              sdata_q;

  // Next-state counters; the frame latch is the edge entering (div 0, slot 0).
  always_comb begin
    div_wrap = (div_cnt == DIV_LAST);
    div_nxt  = div_wrap ? '0 : div_cnt + 1'b1;
    slot_nxt = slot;
    if (div_wrap) begin
      slot_nxt = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    end
    latch = div_wrap && (slot == SLOT_LAST);
  end

  // Left occupies the upper half so it leaves first, MSB-first.
`ifdef I2S_TX_MUTE_EN
  assign load_word = bus.mute ? '0 : {bus.audio_in[0], bus.audio_in[1]};
`else
  assign load_word = {bus.audio_in[0], bus.audio_in[1]};
`endif

  // Counters, shifter and registered outputs. On each bclk fall the data flop
  // takes the shifter MSB; on the latch edge that MSB is still the previous
  // frame's right LSB, which yields the one-bit I2S delay for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= DIV_LAST;
      slot        <= SLOT_LAST;
      shreg       <= '0;
      sample_en_q <= 1'b0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      slot        <= slot_nxt;
      sample_en_q <= latch;
      bclk_q      <= (div_nxt >= DIV_HALF);
      lrclk_q     <= (slot_nxt >= SLOT_RIGHT);
      if (div_wrap) begin
        sdata_q <= shreg[SLOTS-1];
        if (latch) begin
          shreg <= load_word;
        end else begin
          shreg <= {shreg[SLOTS-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.sample_en = sample_en_q;
  assign bus.i2s_bclk  = bclk_q;
  assign bus.i2s_lrclk = lrclk_q;
  assign bus.i2s_sdata = sdata_q;

endmodule
